// File: rtl/wb_queue.sv
// Write-back queue: collects ALU and load completions into a small circular
// FIFO and drains one entry per cycle into the register-file write port.
// Also answers a hazard query: "is a write to register X still pending?".
`timescale 1ns/1ps
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [3:0]               alu_dest,
    input  logic [31:0]              alu_result,
    input  logic                     mem_valid,
    input  logic [3:0]               mem_dest,
    input  logic [31:0]              mem_result,
    input  logic                     freeze,
    input  logic [3:0]               lookup_src,
    output logic                     in_ready,
    output logic                     write_back_en,
    output logic [3:0]               dest_wb,
    output logic [31:0]              result_wb,
    output logic                     lookup_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] result;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wb_en_q, wb_en_d;
    logic [3:0]      dest_wb_q, dest_wb_d;
    logic [31:0]     result_wb_q, result_wb_d;
    logic            ovf_q, ovf_d;

    logic            mem_acc;
    logic            alu_acc;
    logic            pop;
    logic [AW-1:0]   wr_ptr;

    // Space check uses only the current occupancy; a same-cycle pop does not
    // free a slot for this edge's pushes.
    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign mem_acc  = mem_valid & in_ready;
    assign alu_acc  = alu_valid & in_ready;
    // Pop decision looks at occupancy before this edge's pushes, so an entry
    // never leaves on the edge it arrives.
    assign pop      = (count_q != '0) & ~freeze;

    assign count         = count_q;
    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign overflow      = ovf_q;
    assign write_back_en = wb_en_q;
    assign dest_wb       = dest_wb_q;
    assign result_wb     = result_wb_q;

    // Next-state: push (load first, it is older), pop head into write port.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        head_d      = head_q;
        wr_ptr      = tail_q;
        wb_en_d     = 1'b0;
        dest_wb_d   = dest_wb_q;
        result_wb_d = result_wb_q;

        if (pop) begin
            wb_en_d     = 1'b1;
            dest_wb_d   = ent_q[head_q].dest;
            result_wb_d = ent_q[head_q].result;
            head_d      = head_q + AW'(1);
        end

        if (mem_acc) begin
            ent_d[wr_ptr] = '{dest: mem_dest, result: mem_result};
            wr_ptr        = wr_ptr + AW'(1);
        end
        if (alu_acc) begin
            ent_d[wr_ptr] = '{dest: alu_dest, result: alu_result};
            wr_ptr        = wr_ptr + AW'(1);
        end
        tail_d = wr_ptr;

        count_d = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
        ovf_d   = ovf_q | ((alu_valid | mem_valid) & ~in_ready);
    end

    // Hazard query over occupied slots plus the entry on the write port now.
    always_comb begin
        logic [AW-1:0] off;
        lookup_hit = wb_en_q && (dest_wb_q == lookup_src);
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head_q;
            if (({1'b0, off} < count_q) && (ent_q[i].dest == lookup_src))
                lookup_hit = 1'b1;
        end
    end

    // State registers; reset flushes everything, including queued entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            wb_en_q     <= 1'b0;
            dest_wb_q   <= '0;
            result_wb_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            wb_en_q     <= wb_en_d;
            dest_wb_q   <= dest_wb_d;
            result_wb_q <= result_wb_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: stimulus pushes expected writes into a
// scoreboard, a negedge monitor pops and compares every write_back_en pulse.
`timescale 1ns/1ps
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, freeze = 1'b0;
    logic [3:0]  alu_dest = '0, mem_dest = '0, lookup_src = '0;
    logic [31:0] alu_result = '0, mem_result = '0;
    logic        in_ready, write_back_en, lookup_hit, full, empty, overflow;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    int n_wb  = 0;
    logic [35:0] sbq[$];

    wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_result(alu_result),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_result(mem_result),
        .freeze(freeze), .lookup_src(lookup_src), .in_ready(in_ready),
        .write_back_en(write_back_en), .dest_wb(dest_wb), .result_wb(result_wb),
        .lookup_hit(lookup_hit), .count(count), .full(full), .empty(empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [3:0] d, input logic [31:0] r, input bit exp_acc);
        alu_valid = v; alu_dest = d; alu_result = r;
        if (v && exp_acc) sbq.push_back({d, r});
    endtask

    // Caller issues mem before alu on a dual push so the queue order matches.
    task automatic mem(input logic v, input logic [3:0] d, input logic [31:0] r, input bit exp_acc);
        mem_valid = v; mem_dest = d; mem_result = r;
        if (v && exp_acc) sbq.push_back({d, r});
    endtask

    // Monitor: every write-port pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && write_back_en) begin
            n_wb++;
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got dest %0d data 0x%0h, expected no write", dest_wb, result_wb);
            end else begin
                logic [35:0] e;
                e = sbq.pop_front();
                if ({dest_wb, result_wb} !== e) begin
                    fails++;
                    $display("FAIL wb_data: got dest %0d data 0x%0h, expected dest %0d data 0x%0h",
                             dest_wb, result_wb, e[35:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        int base;
        // Reset values
        #2;
        chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1); chk("rst_hit", lookup_hit, 0);
        chk("rst_wb_en", write_back_en, 0); chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0); chk("rst_dest_wb", dest_wb, 0);
        chk("rst_result_wb", result_wb, 0);
        @(negedge clk); rst = 1'b0;
        step();

        // Single write: stored at edge 1, on the port after edge 2 only
        alu(1, 4'd3, 32'hAA, 1);
        step();
        alu(0, 0, 0, 0);
        chk("single_count1", count, 1); chk("single_wb_early", write_back_en, 0);
        step();
        chk("single_wb", write_back_en, 1); chk("single_dest", dest_wb, 3);
        chk("single_res", result_wb, 32'hAA); chk("single_count0", count, 0);
        step();
        chk("single_wb_off", write_back_en, 0); chk("single_hold", dest_wb, 3);

        // Dual completion: load first
        mem(1, 4'd5, 32'h11, 1); alu(1, 4'd6, 32'h22, 1);
        step();
        mem(0, 0, 0, 0); alu(0, 0, 0, 0);
        chk("dual_count2", count, 2);
        step();
        chk("dual_dest5", dest_wb, 5); chk("dual_count1", count, 1);
        step();
        chk("dual_dest6", dest_wb, 6); chk("dual_count0", count, 0);
        step();
        chk("dual_wb_off", write_back_en, 0);

        // Fill / backpressure under freeze
        freeze = 1;
        mem(1, 4'd1, 32'h101, 1); alu(1, 4'd2, 32'h102, 1);
        step();
        chk("fill_count2", count, 2); chk("fill_ready2", in_ready, 1);
        mem(1, 4'd3, 32'h103, 1); alu(1, 4'd4, 32'h104, 1);
        step();
        mem(0, 0, 0, 0);
        chk("fill_count4", count, 4); chk("fill_full", full, 1);
        chk("fill_ready0", in_ready, 0); chk("fill_ovf0", overflow, 0);
        alu(1, 4'd9, 32'hDEAD, 0);
        step();
        alu(0, 0, 0, 0);
        chk("drop_ovf", overflow, 1); chk("drop_count", count, 4);
        chk("freeze_no_wb", write_back_en, 0);
        freeze = 0;
        for (int i = 0; i < 5; i++) step();
        chk("drain_empty", empty, 1); chk("ovf_sticky", overflow, 1);

        // Hazard query
        alu(1, 4'd9, 32'h55, 0); alu_valid = 1'b0;
        lookup_src = 4'd9; alu_valid = 1'b1; #1;
        chk("hit_ignores_inputs", lookup_hit, 0);
        alu_valid = 1'b0;
        step();
        freeze = 1;
        alu(1, 4'd7, 32'h77, 1);
        step();
        alu(0, 0, 0, 0);
        lookup_src = 4'd7; #1;
        chk("hit_7", lookup_hit, 1);
        lookup_src = 4'd8; #1;
        chk("hit_8", lookup_hit, 0);
        lookup_src = 4'd7;
        freeze = 0;
        step();
        chk("hit_wb_en", write_back_en, 1); chk("hit_during_wb", lookup_hit, 1);
        step();
        chk("hit_cleared", lookup_hit, 0);

        // Wrap-around with concurrent drain, duplicate dests included
        base = n_wb;
        for (int i = 0; i < 10; i++) begin
            alu(1, 4'(i % 3), 32'h1000 + 32'(i), 1);
            step();
        end
        alu(0, 0, 0, 0);
        step(); step();
        chk("wrap_writes", n_wb - base, 10); chk("wrap_empty", empty, 1);
        chk("wrap_sb_empty", sbq.size(), 0);

        // Mid-operation reset
        freeze = 1;
        mem(1, 4'd10, 32'hA0, 0); alu(1, 4'd11, 32'hA1, 0);
        step();
        mem(0, 0, 0, 0);
        alu(1, 4'd12, 32'hA2, 0);
        step();
        chk("pre_rst_count", count, 3);
        rst = 1'b1; #1;
        chk("mid_rst_count", count, 0); chk("mid_rst_wb", write_back_en, 0);
        chk("mid_rst_dest", dest_wb, 0); chk("mid_rst_res", result_wb, 0);
        chk("mid_rst_ovf", overflow, 0); chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ready", in_ready, 1);
        step();
        chk("rst_ignores_valid", count, 0);
        alu(0, 0, 0, 0);
        freeze = 0;
        @(negedge clk); rst = 1'b0;
        base = n_wb;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_no_wb", n_wb - base, 0); chk("post_rst_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100us");
        $fatal(1);
    end

endmodule
